instr_fetch: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `decode`. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO. It presents the IF/ID register (`pc_id`, `instr_id`) to decode, honours decode's `stall`, and redirects on decode's jump/branch outputs while preserving the MIPS branch delay slot.

---
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: registered request/address from fetch,
// same-cycle accept (ack) with read data from memory.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC, one-outstanding imem reads, prefetch FIFO, IF/ID register.
// Zero-wait memory gives one instruction per cycle; decode stall holds IF/ID while the FIFO fills.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          jump_branch,
  input  logic          jump_target,
  input  logic          jump_reg,
  input  logic [31:0]   jr_pc,
  output logic [31:0]   pc_id,
  output logic [31:0]   instr_id,
  output logic          valid_id,
  instr_fetch_if.master imem
);
  localparam int          PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(BUF_DEPTH);
  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_DSLOT = 2'd1;
  localparam logic [1:0]  ST_DROP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_tgt_q, pend_tgt_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_id_q, pc_id_d;
  logic [31:0]   instr_id_q, instr_id_d;
  logic          valid_id_q, valid_id_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic [31:0]   buf_instr_q [BUF_DEPTH];

  logic        xfer, fifo_empty, redirect, keep_data, pop, bypass, push;
  logic [31:0] ds, target;

  assign xfer       = req_q & imem.imem_ack;
  assign fifo_empty = (count_q == '0);
  assign redirect   = valid_id_q & ~stall & (jump_branch | jump_target | jump_reg);
  assign ds         = pc_id_q + 32'd4;
  assign target     = jump_reg    ? jr_pc :
                      jump_target ? {ds[31:28], instr_id_q[25:0], 2'b00} :
                                    ds + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};

  // Returned word is discarded while draining a dropped request, or when a
  // redirect keeps only the FIFO head (the delay slot).
  assign keep_data  = xfer & (state_q != ST_DROP) & ~(redirect & ~fifo_empty);
  assign pop        = ~stall & ~fifo_empty;
  assign bypass     = ~stall & fifo_empty & keep_data;
  assign push       = keep_data & ~bypass;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_tgt_d = pend_tgt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    req_d      = req_q;
    addr_d     = addr_q;

    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (redirect && !fifo_empty) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    if (!stall) begin
      if (pop) begin
        pc_id_d    = buf_pc_q[rd_ptr_q];
        instr_id_d = buf_instr_q[rd_ptr_q];
        valid_id_d = 1'b1;
      end else if (bypass) begin
        pc_id_d    = addr_q;
        instr_id_d = imem.imem_rdata;
        valid_id_d = 1'b1;
      end else begin
        instr_id_d = '0;
        valid_id_d = 1'b0;
      end
    end

    case (state_q)
      ST_DSLOT: if (xfer) begin
        fetch_pc_d = pend_tgt_q;
        state_d    = ST_RUN;
      end
      ST_DROP:  if (xfer) state_d = ST_RUN;
      default:  if (xfer) fetch_pc_d = fetch_pc_q + 32'd4;
    endcase

    // The delay slot is either the FIFO head, the in-flight request, or must
    // still be fetched (DSLOT) before the target.
    if (redirect) begin
      if (!fifo_empty) begin
        fetch_pc_d = target;
        if (req_q && !imem.imem_ack) state_d = ST_DROP;
      end else if (req_q) begin
        if (xfer) begin
          fetch_pc_d = target;
        end else begin
          pend_tgt_d = target;
          state_d    = ST_DSLOT;
        end
      end else begin
        fetch_pc_d = ds;
        pend_tgt_d = target;
        state_d    = ST_DSLOT;
      end
    end

    if (req_q && !imem.imem_ack) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d != ST_DROP) && (count_d < FULL_CNT);
      addr_d = req_d ? fetch_pc_d : addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      pend_tgt_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      pc_id_q    <= '0;
      instr_id_q <= '0;
      valid_id_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_tgt_q <= pend_tgt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= addr_q;
      buf_instr_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc_id          = pc_id_q;
  assign instr_id       = instr_id_q;
  assign valid_id       = valid_id_q;
endmodule
